// File: rtl/epcs_flash_slave.sv
// EPCS serial flash slave: decodes READ, RDSR, WREN, WRDI, PP and RDID from an SPI master
// and bridges them onto a simple byte-wide backing-memory port in the sys_clk domain.
module epcs_flash_slave #(
    parameter logic [7:0]  SILICON_ID = 8'h14,
    parameter int unsigned MEM_AW     = 24
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              epcs_dclk,
    input  logic              epcs_sce,
    input  logic              epcs_sdo,
    output logic              epcs_data0,
    output logic              epcs_data0_oe,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata
);

    typedef enum logic [3:0] {
        StIdle, StCmd, StAddr, StDummy, StRdData, StStatus, StRdid, StProg, StIgnore
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  dclk_sync_q, sce_sync_q, sdo_sync_q;
    logic        dclk_prev_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  sr_q, sr_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  tx_q, tx_d;
    logic        data0_q, data0_d;
    logic        oe_q, oe_d;
    logic        mem_rd_q, mem_rd_d;
    logic        rd_dly_q;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wel_q, wel_d;
    logic        armed_q, armed_d;
    logic        is_pp_q, is_pp_d;
    logic        wren_q, wren_d;
    logic        wrdi_q, wrdi_d;
    logic        pp_done_q, pp_done_d;

    logic        dclk_s, sce_s, sdo_s;
    logic        dclk_rise, dclk_fall, last_bit;
    logic [7:0]  byte_in, status;

    assign dclk_s    = dclk_sync_q[1];
    assign sce_s     = sce_sync_q[1];
    assign sdo_s     = sdo_sync_q[1];
    assign dclk_rise = dclk_s & ~dclk_prev_q;
    assign dclk_fall = ~dclk_s & dclk_prev_q;
    assign last_bit  = dclk_rise && (bit_cnt_q == 3'd7);
    assign byte_in   = {sr_q, sdo_s};
    assign status    = {6'b0, wel_q, 1'b0};

    assign epcs_data0    = data0_q;
    assign epcs_data0_oe = oe_q;
    assign mem_addr      = addr_q[MEM_AW-1:0];
    assign mem_rd        = mem_rd_q;
    assign mem_wr        = mem_wr_q;
    assign mem_wdata     = wdata_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            dclk_sync_q <= 2'b0;
            sce_sync_q  <= 2'b0;
            sdo_sync_q  <= 2'b0;
            dclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 2'd0;
            sr_q        <= 7'd0;
            addr_q      <= 24'd0;
            tx_q        <= 8'd0;
            data0_q     <= 1'b0;
            oe_q        <= 1'b0;
            mem_rd_q    <= 1'b0;
            rd_dly_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            wdata_q     <= 8'd0;
            wel_q       <= 1'b0;
            armed_q     <= 1'b0;
            is_pp_q     <= 1'b0;
            wren_q      <= 1'b0;
            wrdi_q      <= 1'b0;
            pp_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dclk_sync_q <= {dclk_sync_q[0], epcs_dclk};
            sce_sync_q  <= {sce_sync_q[0], epcs_sce};
            sdo_sync_q  <= {sdo_sync_q[0], epcs_sdo};
            dclk_prev_q <= dclk_s;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            data0_q     <= data0_d;
            oe_q        <= oe_d;
            mem_rd_q    <= mem_rd_d;
            rd_dly_q    <= mem_rd_q;
            mem_wr_q    <= mem_wr_d;
            wdata_q     <= wdata_d;
            wel_q       <= wel_d;
            armed_q     <= armed_d;
            is_pp_q     <= is_pp_d;
            wren_q      <= wren_d;
            wrdi_q      <= wrdi_d;
            pp_done_q   <= pp_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sr_d       = sr_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        data0_d    = data0_q;
        oe_d       = oe_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        wdata_d    = wdata_q;
        wel_d      = wel_q;
        armed_d    = armed_q;
        is_pp_d    = is_pp_q;
        wren_d     = wren_q;
        wrdi_d     = wrdi_q;
        pp_done_d  = pp_done_q;

        // Page-program address advances the cycle after the strobe so mem_addr is stable with it
        if (mem_wr_q) addr_d[7:0] = addr_q[7:0] + 8'd1;

        if (sce_s) begin
            state_d    = StIdle;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            sr_d       = 7'd0;
            data0_d    = 1'b0;
            oe_d       = 1'b0;
            armed_d    = 1'b1;
            if (wren_q) wel_d = 1'b1;
            if (wrdi_q || pp_done_q) wel_d = 1'b0;
            wren_d     = 1'b0;
            wrdi_d     = 1'b0;
            pp_done_d  = 1'b0;
            is_pp_d    = 1'b0;
        end else begin
            if (dclk_rise && state_q != StIdle) begin
                sr_d      = byte_in[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                // Any bit after WREN/WRDI disqualifies it
                wren_d    = 1'b0;
                wrdi_d    = 1'b0;
            end
            if (dclk_fall && (state_q inside {StRdData, StStatus, StRdid})) begin
                data0_d = tx_q[7];
                tx_d    = {tx_q[6:0], 1'b0};
            end
            if (rd_dly_q) tx_d = mem_rdata;

            unique case (state_q)
                StIdle: if (armed_q) state_d = StCmd;
                StCmd: begin
                    if (last_bit) begin
                        case (byte_in)
                            8'h03: begin
                                state_d = StAddr;
                                is_pp_d = 1'b0;
                            end
                            8'h02: begin
                                state_d = wel_q ? StAddr : StIgnore;
                                is_pp_d = wel_q;
                            end
                            8'h05: begin
                                state_d = StStatus;
                                tx_d    = status;
                                oe_d    = 1'b1;
                            end
                            8'hAB: state_d = StDummy;
                            8'h06: begin
                                state_d = StIgnore;
                                wren_d  = 1'b1;
                            end
                            8'h04: begin
                                state_d = StIgnore;
                                wrdi_d  = 1'b1;
                            end
                            default: state_d = StIgnore;
                        endcase
                    end
                end
                StAddr: begin
                    if (dclk_rise) addr_d = {addr_q[22:0], sdo_s};
                    if (last_bit) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd2) begin
                            byte_cnt_d = 2'd0;
                            if (is_pp_q) begin
                                state_d = StProg;
                            end else begin
                                state_d  = StRdData;
                                oe_d     = 1'b1;
                                mem_rd_d = 1'b1;
                            end
                        end
                    end
                end
                StDummy: begin
                    if (last_bit) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd2) begin
                            byte_cnt_d = 2'd0;
                            state_d    = StRdid;
                            tx_d       = SILICON_ID;
                            oe_d       = 1'b1;
                        end
                    end
                end
                StRdData: begin
                    if (last_bit) begin
                        addr_d                = 24'd0;
                        addr_d[MEM_AW-1:0]    = addr_q[MEM_AW-1:0] + MEM_AW'(1);
                        mem_rd_d              = 1'b1;
                    end
                end
                StStatus: if (last_bit) tx_d = status;
                StRdid:   if (last_bit) tx_d = SILICON_ID;
                StProg: begin
                    if (last_bit) begin
                        mem_wr_d  = 1'b1;
                        wdata_d   = byte_in;
                        pp_done_d = 1'b1;
                    end
                end
                StIgnore: ;
                default:  state_d = StIdle;
            endcase
        end
    end

endmodule
